// File: rtl/usr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// usr_seq_ctrl
// Command sequencer for a universal shift register. A host hands over one
// LOAD / SHR / SHL / ROTR command through a valid/ready handshake. The
// controller then drives the register's mode, parallel data and serial-fill
// inputs for the required number of cycles. When the command completes it
// captures the register contents into `result` and pulses `done`.
//
// Optional feature macro: USR_SEQ_CTRL_ROTATE_EN
//   defined   : ROTR rotates right `cmd_count` times (LSB fed back to MSB)
//   undefined : ROTR is accepted but runs as a count-0 no-op
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    controller can accept a command (IDLE and out of reset)
//   cmd_op       00 LOAD, 01 SHR, 10 SHL, 11 ROTR
//   cmd_fill     serial fill bit for SHR/SHL
//   cmd_count    shift count (ignored for LOAD)
//   cmd_data     parallel load value
//   sr_mode      register mode: 00 hold, 01 right, 10 left, 11 load
//   sr_data_in   register parallel input (latched cmd_data)
//   sr_sin_left  register left-shift serial input
//   sr_sin_right register right-shift serial input
//   sr_data_out  register contents
//   busy         command in progress
//   done         one-cycle completion pulse
//   result       register contents captured at completion
// ---------------------------------------------------------------------------
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             sr_sin_left,
  output logic             sr_sin_right,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_CAPT  = 2'b11
  } state_e;

  state_e           state_q,  state_d;
  logic [1:0]       op_q,     op_d;
  logic             fill_q,   fill_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic [1:0]       mode_q,   mode_d;
  logic             sin_l_q,  sin_l_d;
  logic             sin_r_q,  sin_r_d;
  logic             rot_q,    rot_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    mode_d   = mode_q;
    sin_l_d  = sin_l_q;
    sin_r_d  = sin_r_q;
    rot_d    = rot_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Every field is latched on acceptance; later input changes are ignored.
          op_d   = cmd_op;
          fill_d = cmd_fill;
          cnt_d  = cmd_count;
          data_d = cmd_data;
          case (cmd_op)
            OP_LOAD: begin
              state_d = S_LOAD;
              mode_d  = MODE_LOAD;
            end
            OP_SHR: begin
              if (cmd_count != CNT_ZERO) begin
                state_d = S_SHIFT;
                mode_d  = MODE_RIGHT;
                sin_r_d = cmd_fill;
              end else begin
                state_d = S_CAPT;
              end
            end
            OP_SHL: begin
              if (cmd_count != CNT_ZERO) begin
                state_d = S_SHIFT;
                mode_d  = MODE_LEFT;
                sin_l_d = cmd_fill;
              end else begin
                state_d = S_CAPT;
              end
            end
            OP_ROTR: begin
`ifdef USR_SEQ_CTRL_ROTATE_EN
              if (cmd_count != CNT_ZERO) begin
                state_d = S_SHIFT;
                mode_d  = MODE_RIGHT;
                rot_d   = 1'b1;
              end else begin
                state_d = S_CAPT;
              end
`else
              // Rotation not built in: behave as a count-0 command.
              state_d = S_CAPT;
`endif
            end
            default: begin
              state_d = S_CAPT;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        state_d = S_CAPT;
        mode_d  = MODE_HOLD;
      end

      S_SHIFT: begin
        // The last shift happens on the edge that leaves SHIFT.
        if (cnt_q <= CNT_ONE) begin
          state_d = S_CAPT;
          mode_d  = MODE_HOLD;
          sin_l_d = 1'b0;
          sin_r_d = 1'b0;
          rot_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_CAPT: begin
        state_d  = S_IDLE;
        result_d = sr_data_out;
        done_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        mode_d  = MODE_HOLD;
        sin_l_d = 1'b0;
        sin_r_d = 1'b0;
        rot_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      fill_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
      data_q   <= '0;
      mode_q   <= MODE_HOLD;
      sin_l_q  <= 1'b0;
      sin_r_q  <= 1'b0;
      rot_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      sin_l_q  <= sin_l_d;
      sin_r_q  <= sin_r_d;
      rot_q    <= rot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign cmd_ready    = reset & (state_q == S_IDLE);
  assign sr_mode      = mode_q;
  assign sr_data_in   = data_q;
  assign sr_sin_left  = sin_l_q;
  // Rotation feeds the live LSB back into the MSB on every shift.
  assign sr_sin_right = rot_q ? sr_data_out[0] : sin_r_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usr_seq_ctrl
// Bench for usr_seq_ctrl. It contains a behavioural 4-bit universal shift
// register that closes the loop, a command-level reference model and a
// scoreboard of expected {result, done cycle}. An entry is pushed when each
// command is accepted, and is popped and compared when `done` appears.
// ---------------------------------------------------------------------------
module tb_usr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_fill = 1'b0;
  logic [2:0] cmd_count = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [1:0] sr_mode;
  logic [3:0] sr_data_in;
  logic       sr_sin_left;
  logic       sr_sin_right;
  logic [3:0] sr_data_out;
  logic       busy;
  logic       done;
  logic [3:0] result;

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fill(cmd_fill), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .sr_mode(sr_mode), .sr_data_in(sr_data_in),
    .sr_sin_left(sr_sin_left), .sr_sin_right(sr_sin_right),
    .sr_data_out(sr_data_out),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register (the datapath being sequenced).
  logic [3:0] sr_q = 4'd0;
  always @(posedge clk) begin
    case (sr_mode)
      2'b01:   sr_q <= {sr_sin_right, sr_q[3:1]};
      2'b10:   sr_q <= {sr_q[2:0], sr_sin_left};
      2'b11:   sr_q <= sr_data_in;
      default: sr_q <= sr_q;
    endcase
  end
  assign sr_data_out = sr_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Activity counters sampled on the falling edge.
  int n_m1 = 0, n_m2 = 0, n_m3 = 0, n_sr1 = 0, n_done = 0;
  always @(negedge clk) begin
    if (sr_mode == 2'b01) n_m1 <= n_m1 + 1;
    if (sr_mode == 2'b10) n_m2 <= n_m2 + 1;
    if (sr_mode == 2'b11) n_m3 <= n_m3 + 1;
    if (sr_mode == 2'b01 && sr_sin_right) n_sr1 <= n_sr1 + 1;
    if (done) n_done <= n_done + 1;
  end

  typedef struct {
    logic [3:0] res;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_cmd_done = 0;
  logic [3:0] ref_val = 4'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    else n_pass++;
  endtask

  // Command-level reference: register value after a command completes.
  function automatic logic [3:0] ref_apply(input logic [1:0] op, input logic fill,
                                           input logic [2:0] cnt, input logic [3:0] data,
                                           input logic [3:0] cur);
    logic [3:0] r;
    r = cur;
    case (op)
      2'b00: r = data;
      2'b01: for (int i = 0; i < int'(cnt); i++) r = {fill, r[3:1]};
      2'b10: for (int i = 0; i < int'(cnt); i++) r = {r[2:0], fill};
      default: begin
`ifdef USR_SEQ_CTRL_ROTATE_EN
        for (int i = 0; i < int'(cnt); i++) r = {r[0], r[3:1]};
`else
        r = cur;
`endif
      end
    endcase
    return r;
  endfunction

  // Edges from acceptance to the cycle where done is visible.
  function automatic int ref_lat(input logic [1:0] op, input logic [2:0] cnt);
    if (op == 2'b00) return 2;
`ifndef USR_SEQ_CTRL_ROTATE_EN
    if (op == 2'b11) return 1;
`endif
    if (cnt == 3'd0) return 1;
    return int'(cnt) + 1;
  endfunction

  task automatic send(input logic [1:0] op, input logic fill, input logic [2:0] cnt,
                      input logic [3:0] data, output int c0);
    exp_t e;
    int tmo;
    tmo = 0;
    c0 = -1;
    while (!cmd_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!cmd_ready) begin
      check_val("ready_timeout", 32'd0, 32'd1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_fill = fill;
      cmd_count = cnt;
      cmd_data = data;
      @(posedge clk);
      @(negedge clk);
      c0 = cyc;
      // Scramble inputs after acceptance: the controller must use latched copies.
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom_range(3, 0));
      cmd_fill = ~fill;
      cmd_count = 3'($urandom_range(7, 0));
      cmd_data = ~data;
      e.res = ref_apply(op, fill, cnt, data, ref_val);
      e.cyc = c0 + ref_lat(op, cnt);
      ref_val = e.res;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output int dcyc);
    exp_t e;
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      dcyc = cyc;
      n_cmd_done++;
      check_val("result", 32'(result), 32'(e.res));
      check_val("done_cycle", dcyc, e.cyc);
    end else begin
      check_val("done_seen", 32'(seen), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  int c0, dc, m1, m2, m3, s1, nd;

  initial begin
    // Reset held from time zero; sample mid-cycle.
    #12;
    check_val("rst_mode", 32'(sr_mode), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_busy_done", 32'({busy, done}), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_din_sin", 32'({sr_data_in, sr_sin_left, sr_sin_right}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("post_rst_ready", 32'(cmd_ready), 32'd1);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    // LOAD 1010: exactly one load cycle.
    m3 = n_m3;
    send(2'b00, 1'b0, 3'd5, 4'b1010, c0);
    wait_done(dc);
    check_val("load_mode_cycles", n_m3 - m3, 32'd1);

    // SHR by 2 with fill 1: 1010 -> 1110.
    m1 = n_m1; s1 = n_sr1;
    send(2'b01, 1'b1, 3'd2, 4'b0000, c0);
    wait_done(dc);
    check_val("shr_mode_cycles", n_m1 - m1, 32'd2);
    check_val("shr_sin_right", n_sr1 - s1, 32'd2);

    // SHL by 2 with fill 0: 1110 -> 1000.
    m2 = n_m2;
    send(2'b10, 1'b0, 3'd2, 4'b1111, c0);
    wait_done(dc);
    check_val("shl_mode_cycles", n_m2 - m2, 32'd2);

    // ROTR by 5 (wraps to 1) when rotation is built, else a no-op.
    m1 = n_m1; m2 = n_m2; m3 = n_m3;
    send(2'b11, 1'b1, 3'd5, 4'b0000, c0);
    wait_done(dc);
`ifdef USR_SEQ_CTRL_ROTATE_EN
    check_val("rotr_mode_cycles", n_m1 - m1, 32'd5);
`else
    check_val("rotr_mode_idle", (n_m1 - m1) + (n_m2 - m2) + (n_m3 - m3), 32'd0);
`endif

    // Count-0 SHL, then a LOAD presented in the done cycle.
    m1 = n_m1; m2 = n_m2; m3 = n_m3;
    send(2'b10, 1'b1, 3'd0, 4'b0000, c0);
    wait_done(dc);
    check_val("cnt0_mode_idle", (n_m1 - m1) + (n_m2 - m2) + (n_m3 - m3), 32'd0);
    send(2'b00, 1'b0, 3'd0, 4'b0110, c0);
    check_val("b2b_accept_edge", c0, dc + 1);
    wait_done(dc);

    // Saturating counts beyond the width.
    send(2'b01, 1'b1, 3'd7, 4'b0000, c0);
    wait_done(dc);
    send(2'b10, 1'b0, 3'd5, 4'b0000, c0);
    wait_done(dc);

    // Rotation by 7 (wraps to 3).
    send(2'b00, 1'b0, 3'd0, 4'b1001, c0);
    wait_done(dc);
    send(2'b11, 1'b0, 3'd7, 4'b0000, c0);
    wait_done(dc);

    // SHR by 7 abandoned by reset during the third shift cycle.
    send(2'b01, 1'b1, 3'd7, 4'b0101, c0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    void'(exp_q.pop_front());
    nd = n_done;
    check_val("abort_mode", 32'(sr_mode), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_ready", 32'(cmd_ready), 32'd0);
    check_val("abort_result", 32'(result), 32'd0);
    check_val("abort_din_sin", 32'({sr_data_in, sr_sin_left, sr_sin_right}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort_no_done", n_done - nd, 32'd0);
    check_val("abort_result_hold", 32'(result), 32'd0);
    check_val("abort_idle", 32'({cmd_ready, busy}), 32'b10);

    check_val("done_pulses", n_done, n_cmd_done);
    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
